// File: rtl/wb_master_standard.sv
// Wishbone classic single-transfer master: req/rsp handshake in, one WB cycle out.
// Optional BUS-phase timeout is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_standard #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_adr,
    input  logic [DW-1:0]   req_dat,
    input  logic [DW/8-1:0] req_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_m,
    output logic [DW/8-1:0] wb_sel,
    input  logic [DW-1:0]   wb_dat_s,
    input  logic            wb_ack,
    input  logic            wb_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [DW-1:0]     rsp_dat_q, rsp_dat_d;

    // Classic mode: stall has no meaning for single transfers.
    logic unused_stall;
    assign unused_stall = wb_stall;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 256) ? 8 : 16;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          err_q, err_d;
    assign cnt_inc = cnt_q + 1'b1;
    assign rsp_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign rsp_err = 1'b0;
`endif

    // Bus strobes and handshakes decode straight from the state register.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign wb_cyc    = (state_q == BUS);
    assign wb_stb    = (state_q == BUS);
    assign wb_we     = we_q;
    assign wb_adr    = adr_q;
    assign wb_dat_m  = dat_q;
    assign wb_sel    = sel_q;
    assign rsp_dat   = rsp_dat_q;

    // Next-state and capture logic; ack has priority over timeout.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    adr_d   = req_adr;
                    dat_d   = req_dat;
                    sel_d   = req_sel;
                    state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                if (wb_ack) begin
                    rsp_dat_d = we_q ? '0 : wb_dat_s;
                    state_d   = RESP;
`ifdef WB_MASTER_TIMEOUT_EN
                    err_d     = 1'b0;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    rsp_dat_d = '0;
                    err_d     = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = RESP;
                end else begin
                    cnt_d     = cnt_inc;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_master_standard.sv
// Directed bench for wb_master_standard: vector table plus corner sequences.
// Timeout checks follow WB_MASTER_TIMEOUT_EN (TIMEOUT = 8 here).
module tb_wb_master_standard;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int MAXC = 400;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_adr;
    logic [DW-1:0]   req_dat;
    logic [DW/8-1:0] req_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_dat;
    logic            rsp_err;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [AW-1:0]   wb_adr;
    logic [DW-1:0]   wb_dat_m;
    logic [DW/8-1:0] wb_sel;
    logic [DW-1:0]   wb_dat_s;
    logic            wb_ack;
    logic            wb_stall;

    int n_cmp;
    int n_fail;

    wb_master_standard #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_adr(req_adr),
        .req_dat(req_dat),
        .req_sel(req_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat),
        .rsp_err(rsp_err),
        .wb_cyc(wb_cyc),
        .wb_stb(wb_stb),
        .wb_we(wb_we),
        .wb_adr(wb_adr),
        .wb_dat_m(wb_dat_m),
        .wb_sel(wb_sel),
        .wb_dat_s(wb_dat_s),
        .wb_ack(wb_ack),
        .wb_stall(wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;
        logic [31:0] sdat;
        logic [31:0] exp_dat;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    // One full request/WB cycle/response; slave acks 'delay' cycles after stb.
    task automatic do_txn(input string tag, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int delay,
                          input logic [31:0] sdat, input int exp_len,
                          input logic [31:0] exp_dat, input logic exp_err);
        int  n;
        logic stable;
        chk(tag, "req_ready idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        req_sel   = sel;
        step();
        req_valid = 1'b0;
        req_we    = ~we;
        req_adr   = ~adr;
        req_dat   = ~dat;
        req_sel   = ~sel;
        n = 0;
        stable = 1'b1;
        while (wb_cyc === 1'b1 && n < MAXC) begin
            if (!(wb_stb === 1'b1 && wb_adr === adr && wb_dat_m === dat &&
                  wb_we === we && wb_sel === sel && req_ready === 1'b0))
                stable = 1'b0;
            wb_ack   = (n == delay);
            wb_dat_s = (n == delay) ? sdat : ~sdat;
            n++;
            step();
        end
        wb_ack = 1'b0;
        chk(tag, "bus stable", {63'd0, stable}, 64'd1);
        chk(tag, "cyc length", 64'(n), 64'(exp_len));
        chk(tag, "stb after", {63'd0, wb_stb}, 64'd0);
        chk(tag, "rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk(tag, "rsp_dat", {32'd0, rsp_dat}, {32'd0, exp_dat});
        chk(tag, "rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk(tag, "rsp_valid drop", {63'd0, rsp_valid}, 64'd0);
        chk(tag, "req_ready back", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic        trace[16];
        logic [31:0] got[$];
        logic [31:0] held;
        int          issued;
        logic        accept;
        int          i1, j1, i2, highs;

        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        rsp_ready = 1'b0;
        wb_dat_s = '0;
        wb_ack = 1'b0;
        wb_stall = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 3,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1,
                    32'hAAAA_5555, 32'h0,         2};
        vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'h3, 0,
                    32'h0000_00A5, 32'h0000_00A5, 1};
        vecs[3] = '{1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h1, 5,
                    32'h7777_7777, 32'h0,         6};
        vecs[4] = '{1'b0, 32'h0000_0100, 32'h5555_AAAA, 4'hC, 2,
                    32'h0,         32'h0,         3};

        // reset values
        step();
        step();
        chk("reset", "wb_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("reset", "wb_stb", {63'd0, wb_stb}, 64'd0);
        chk("reset", "wb_we", {63'd0, wb_we}, 64'd0);
        chk("reset", "wb_adr", {32'd0, wb_adr}, 64'd0);
        chk("reset", "wb_dat_m", {32'd0, wb_dat_m}, 64'd0);
        chk("reset", "wb_sel", {60'd0, wb_sel}, 64'd0);
        chk("reset", "rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset", "rsp_dat", {32'd0, rsp_dat}, 64'd0);
        chk("reset", "rsp_err", {63'd0, rsp_err}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("reset", "req_ready release", {63'd0, req_ready}, 64'd1);

        // vector table
        for (int v = 0; v < 5; v++) begin
            do_txn($sformatf("vec%0d", v), vecs[v].we, vecs[v].adr,
                   vecs[v].dat, vecs[v].sel, vecs[v].delay, vecs[v].sdat,
                   vecs[v].exp_len, vecs[v].exp_dat, 1'b0);
        end

        // stray ack while idle
        wb_ack = 1'b1;
        wb_dat_s = 32'h1111_2222;
        step();
        wb_ack = 1'b0;
        chk("idle_ack", "wb_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("idle_ack", "rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("idle_ack", "req_ready", {63'd0, req_ready}, 64'd1);

        // backpressure: response held, no new request, stray acks ignored
        req_valid = 1'b1;
        req_we = 1'b0;
        req_adr = 32'h40;
        req_sel = 4'hF;
        step();
        req_valid = 1'b0;
        wb_ack = 1'b1;
        wb_dat_s = 32'hCAFE_F00D;
        step();
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            wb_ack = 1'b1;
            wb_dat_s = 32'h0101_0101 * (k + 2);
            chk("bp", "rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp", "rsp_dat", {32'd0, rsp_dat}, 64'hCAFE_F00D);
            chk("bp", "req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp", "wb_cyc", {63'd0, wb_cyc}, 64'd0);
            step();
        end
        req_valid = 1'b0;
        wb_ack = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp", "req_ready end", {63'd0, req_ready}, 64'd1);
        chk("bp", "wb_cyc end", {63'd0, wb_cyc}, 64'd0);

        // back-to-back reads, zero-wait slave, rsp_ready held high
        issued = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_adr = 32'h0000_0A00;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            trace[c] = wb_cyc;
            if (rsp_valid) got.push_back(rsp_dat);
            accept = req_ready && req_valid;
            wb_ack = wb_cyc;
            wb_dat_s = wb_cyc ? {wb_adr[15:0], 16'hC0DE} : 32'h0;
            step();
            if (accept) begin
                issued++;
                if (issued == 2) req_valid = 1'b0;
                else req_adr = 32'h0000_0B00;
            end
        end
        wb_ack = 1'b0;
        rsp_ready = 1'b0;
        i1 = -1; j1 = -1; i2 = -1; highs = 0;
        for (int c = 0; c < 16; c++) begin
            if (trace[c]) highs++;
            if (trace[c] && i1 < 0) i1 = c;
            else if (!trace[c] && i1 >= 0 && j1 < 0) j1 = c;
            else if (trace[c] && j1 >= 0 && i2 < 0) i2 = c;
        end
        // gap = RESP cycle + IDLE accept cycle
        chk("b2b", "cyc high count", 64'(highs), 64'd2);
        chk("b2b", "first len", 64'(j1 - i1), 64'd1);
        chk("b2b", "gap", 64'(i2 - j1), 64'd2);
        chk("b2b", "rsp count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("b2b", "rsp0", {32'd0, got[0]}, 64'h0A00_C0DE);
            chk("b2b", "rsp1", {32'd0, got[1]}, 64'h0B00_C0DE);
        end

`ifdef WB_MASTER_TIMEOUT_EN
        do_txn("timeout", 1'b0, 32'h50, 32'h0, 4'hF, 1000, 32'h9999_9999,
               TO, 32'h0, 1'b1);
        do_txn("ack_at_to", 1'b0, 32'h54, 32'h0, 4'hF, TO - 1,
               32'h1357_9BDF, TO, 32'h1357_9BDF, 1'b0);
`else
        do_txn("no_timeout", 1'b0, 32'h50, 32'h0, 4'hF, 300, 32'h2468_ACE0,
               301, 32'h2468_ACE0, 1'b0);
`endif

        // reset two cycles into BUS
        req_valid = 1'b1;
        req_we = 1'b1;
        req_adr = 32'h60;
        req_dat = 32'h0F0F_0F0F;
        step();
        req_valid = 1'b0;
        chk("rst_mid", "cyc in bus", {63'd0, wb_cyc}, 64'd1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "wb_cyc async", {63'd0, wb_cyc}, 64'd0);
        chk("rst_mid", "wb_stb async", {63'd0, wb_stb}, 64'd0);
        chk("rst_mid", "rsp_valid", {63'd0, rsp_valid}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_mid", "req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mid", "rsp_valid after", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mid", "wb_adr", {32'd0, wb_adr}, 64'd0);

        held = 32'h0;
        held = held + 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
